// File: rtl/pll_reconfig_ctrl.sv
// PLLA MD-port reconfiguration controller: writes MDIV/ODIV0 under PLL reset,
// verifies each by read-back, releases reset and waits for lock.
module pll_reconfig_ctrl #(
  parameter logic [7:0]  ADDR_MDIV    = 8'h04,
  parameter logic [7:0]  ADDR_ODIV0   = 8'h0C,
  parameter int unsigned RD_LAT       = 2,
  parameter int unsigned RST_HOLD     = 16,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_mdiv,
  input  logic [7:0] req_odiv0,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic       pll_reset,
  input  logic       pll_lock,
  output logic       locked,
  output logic [1:0] mdopc,
  output logic       mdainc,
  output logic [7:0] mdwdi,
  input  logic [7:0] mdrdo
);

  localparam logic [15:0] HOLD_END = 16'(RST_HOLD - 1);
  localparam logic [15:0] RD_END   = 16'(RD_LAT - 1);
  localparam logic [15:0] LOCK_END = 16'(LOCK_TIMEOUT - 1);

  localparam logic [1:0] OPC_NOP  = 2'b00;
  localparam logic [1:0] OPC_WR   = 2'b01;
  localparam logic [1:0] OPC_RD   = 2'b10;
  localparam logic [1:0] OPC_ADDR = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST_ASSERT,
    S_ADDR,
    S_WRITE,
    S_READ,
    S_RD_WAIT,
    S_CHECK,
    S_RELEASE,
    S_WAIT_LOCK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic        sel, sel_n;
  logic [7:0]  mdiv_q, mdiv_n;
  logic [7:0]  odiv_q, odiv_n;
  logic [7:0]  sample, sample_n;
  logic [1:0]  code_n;
  logic [1:0]  opc_n;
  logic [7:0]  wdi_n;
  logic [7:0]  wval;
  logic        prst_n;
  logic        sync1;

  assign mdainc = 1'b0;
  assign wval   = sel ? odiv_q : mdiv_q;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    sel_n    = sel;
    mdiv_n   = mdiv_q;
    odiv_n   = odiv_q;
    sample_n = sample;
    code_n   = err_code;
    unique case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          state_n = S_RST_ASSERT;
          mdiv_n  = req_mdiv;
          odiv_n  = req_odiv0;
          code_n  = 2'b00;
          sel_n   = 1'b0;
          cnt_n   = '0;
        end
      end
      S_RST_ASSERT: begin
        if (cnt == HOLD_END) begin
          state_n = S_ADDR;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_ADDR:  state_n = S_WRITE;
      S_WRITE: state_n = S_READ;
      S_READ: begin
        state_n = S_RD_WAIT;
        cnt_n   = '0;
      end
      S_RD_WAIT: begin
        if (cnt == RD_END) begin
          sample_n = mdrdo;
          state_n  = S_CHECK;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_CHECK: begin
        if (sample != wval) begin
          code_n  = 2'b01;
          state_n = S_ERROR;
        end else if (!sel) begin
          sel_n   = 1'b1;
          state_n = S_ADDR;
        end else begin
          state_n = S_RELEASE;
          cnt_n   = '0;
        end
      end
      // counter runs from RELEASE so timeout lands LOCK_TIMEOUT cycles after it
      S_RELEASE: begin
        state_n = S_WAIT_LOCK;
        cnt_n   = cnt + 16'd1;
      end
      S_WAIT_LOCK: begin
        if (locked) begin
          state_n = S_DONE;
        end else if (cnt == LOCK_END) begin
          code_n  = 2'b10;
          state_n = S_ERROR;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_DONE:  state_n = S_IDLE;
      S_ERROR: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    opc_n = OPC_NOP;
    wdi_n = 8'h00;
    unique case (1'b1)
      (state_n == S_ADDR): begin
        opc_n = OPC_ADDR;
        wdi_n = sel_n ? ADDR_ODIV0 : ADDR_MDIV;
      end
      (state_n == S_WRITE): begin
        opc_n = OPC_WR;
        wdi_n = sel_n ? odiv_n : mdiv_n;
      end
      (state_n == S_READ): opc_n = OPC_RD;
      default: ;
    endcase
  end

  assign prst_n = (state_n == S_RST_ASSERT) || (state_n == S_ADDR) ||
                  (state_n == S_WRITE) || (state_n == S_READ) ||
                  (state_n == S_RD_WAIT) || (state_n == S_CHECK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      sel       <= 1'b0;
      mdiv_q    <= 8'h00;
      odiv_q    <= 8'h00;
      sample    <= 8'h00;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'b00;
      pll_reset <= 1'b0;
      mdopc     <= OPC_NOP;
      mdwdi     <= 8'h00;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sel       <= sel_n;
      mdiv_q    <= mdiv_n;
      odiv_q    <= odiv_n;
      sample    <= sample_n;
      req_ready <= (state_n == S_IDLE);
      busy      <= (state_n != S_IDLE);
      done      <= (state_n == S_DONE);
      err       <= (state_n == S_ERROR);
      err_code  <= code_n;
      pll_reset <= prst_n;
      mdopc     <= opc_n;
      mdwdi     <= wdi_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      locked <= 1'b0;
    end else begin
      sync1  <= pll_lock;
      locked <= sync1;
    end
  end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl with an echoing MD-port PLL model.
// Cycle 0 is the handshake cycle; end cycles are counted from it.
module tb_pll_reconfig_ctrl;

  localparam int RST_HOLD = 16;
  localparam int RD_LAT   = 2;
  localparam int LOCK_TO  = 1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_mdiv = 8'h00;
  logic [7:0] req_odiv0 = 8'h00;
  logic       busy, done, err;
  logic [1:0] err_code;
  logic       pll_reset;
  logic       pll_lock = 1'b0;
  logic       locked;
  logic [1:0] mdopc;
  logic       mdainc;
  logic [7:0] mdwdi;
  logic [7:0] mdrdo;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pll_reconfig_ctrl #(
    .ADDR_MDIV(8'h04),
    .ADDR_ODIV0(8'h0C),
    .RD_LAT(RD_LAT),
    .RST_HOLD(RST_HOLD),
    .LOCK_TIMEOUT(LOCK_TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_mdiv(req_mdiv),
    .req_odiv0(req_odiv0),
    .busy(busy),
    .done(done),
    .err(err),
    .err_code(err_code),
    .pll_reset(pll_reset),
    .pll_lock(pll_lock),
    .locked(locked),
    .mdopc(mdopc),
    .mdainc(mdainc),
    .mdwdi(mdwdi),
    .mdrdo(mdrdo)
  );

  // PLL MD-port model: address register, register file, read pipeline
  logic [7:0] mem [256];
  logic [7:0] maddr = 8'h00;
  logic [7:0] pipe [RD_LAT];
  logic [7:0] bad_addr = 8'h00;

  always @(posedge clk) begin
    if (mdopc == 2'b11) maddr <= mdwdi;
    if (mdopc == 2'b01) mem[maddr] <= mdwdi;
    if (mdopc == 2'b10)
      pipe[0] <= (bad_addr != 8'h00 && maddr == bad_addr) ? 8'h00 : mem[maddr];
    else
      pipe[0] <= 8'h5A;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end

  assign mdrdo = pipe[RD_LAT-1];

  logic [9:0] bus_q [$];

  typedef struct {
    logic [7:0] mdiv;
    logic [7:0] odiv;
    logic [7:0] bad;
    int         d;
    bit         exp_done;
    logic [1:0] exp_code;
    int         exp_cyc;
    int         exp_nbus;
    int         exp_rsthi;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  task automatic start_req(input logic [7:0] m, input logic [7:0] o,
                           input bit hold);
    @(negedge clk);
    req_valid = 1'b1;
    req_mdiv  = m;
    req_odiv0 = o;
    chk("req_ready_at_handshake", req_ready, 1);
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  // d < 0: lock never rises; else pll_lock rises d cycles after release
  task automatic run_until_end(input int d, output int c_end,
                               output bit was_done, output int rst_hi);
    int rel;
    bit seen_hi;
    rel = -1;
    seen_hi = 0;
    rst_hi = 0;
    c_end = -1;
    was_done = 0;
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("busy_first_cycle", busy, 1);
        chk("req_ready_first_cycle", req_ready, 0);
        chk("err_code_cleared", err_code, 0);
      end
      chk("mdainc_zero", mdainc, 0);
      if (pll_reset) begin
        rst_hi++;
        seen_hi = 1;
      end else if (seen_hi && rel < 0) begin
        rel = c;
      end
      if (rel >= 0 && d >= 0 && c == rel + d) pll_lock = 1'b1;
      if (mdopc != 2'b00) bus_q.push_back({mdopc, mdwdi});
      if (done || err) begin
        c_end = c;
        was_done = done;
        break;
      end
    end
  endtask

  task automatic do_vec(input vec_t v, input string tag);
    int c_end, rh;
    bit wd;
    logic [9:0] e [6];
    e[0] = {2'b11, 8'h04};
    e[1] = {2'b01, v.mdiv};
    e[2] = {2'b10, 8'h00};
    e[3] = {2'b11, 8'h0C};
    e[4] = {2'b01, v.odiv};
    e[5] = {2'b10, 8'h00};
    bad_addr = v.bad;
    pll_lock = 1'b0;
    bus_q.delete();
    start_req(v.mdiv, v.odiv, 0);
    run_until_end(v.d, c_end, wd, rh);
    chk({tag, " end_cycle"}, c_end, v.exp_cyc);
    chk({tag, " done_not_err"}, int'(wd), int'(v.exp_done));
    chk({tag, " err_code"}, err_code, v.exp_code);
    chk({tag, " pll_reset_cycles"}, rh, v.exp_rsthi);
    chk({tag, " bus_ops"}, bus_q.size(), v.exp_nbus);
    for (int i = 0; i < 6; i++)
      if (i < v.exp_nbus && i < bus_q.size())
        chk($sformatf("%s bus[%0d]", tag, i), bus_q[i], e[i]);
    @(negedge clk);
    chk({tag, " pulse_done_once"}, done, 0);
    chk({tag, " pulse_err_once"}, err, 0);
    chk({tag, " idle_ready"}, req_ready, 1);
    chk({tag, " idle_busy"}, busy, 0);
    chk({tag, " pll_reset_low"}, pll_reset, 0);
    chk({tag, " err_code_hold"}, err_code, v.exp_code);
  endtask

  vec_t vt [7];

  initial begin
    int c_end, rh;
    bit wd, found;
    vec_t va;

    vt[0] = '{8'h1E, 8'h12, 8'h00,  100, 1'b1, 2'b00,  132, 6, 28};
    vt[1] = '{8'hFF, 8'h00, 8'h00,    0, 1'b1, 2'b00,   32, 6, 28};
    vt[2] = '{8'h1E, 8'h12, 8'h04,  100, 1'b0, 2'b01,   23, 3, 22};
    vt[3] = '{8'h3C, 8'h07, 8'h0C,  100, 1'b0, 2'b01,   29, 6, 28};
    vt[4] = '{8'h20, 8'h04, 8'h00,  997, 1'b1, 2'b00, 1029, 6, 28};
    vt[5] = '{8'h20, 8'h04, 8'h00,  998, 1'b0, 2'b10, 1029, 6, 28};
    vt[6] = '{8'hA5, 8'h5A, 8'h00,   -1, 1'b0, 2'b10, 1029, 6, 28};

    #23;
    chk("rst req_ready", req_ready, 1);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    chk("rst err_code", err_code, 0);
    chk("rst pll_reset", pll_reset, 0);
    chk("rst mdopc", mdopc, 0);
    chk("rst mdwdi", mdwdi, 0);
    chk("rst locked", locked, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) do_vec(vt[i], $sformatf("vec%0d", i));

    // request held high through a busy transaction with changing data
    bad_addr = 8'h00;
    pll_lock = 1'b0;
    bus_q.delete();
    start_req(8'h40, 8'h08, 1);
    req_mdiv = 8'h41;
    req_odiv0 = 8'h09;
    run_until_end(3, c_end, wd, rh);
    chk("busy1 end_cycle", c_end, 35);
    chk("busy1 done", int'(wd), 1);
    chk("busy1 nbus", bus_q.size(), 6);
    if (bus_q.size() == 6) begin
      chk("busy1 mdiv_write", bus_q[1], {2'b01, 8'h40});
      chk("busy1 odiv_write", bus_q[4], {2'b01, 8'h08});
    end
    @(negedge clk);
    chk("busy2 ready_after_done", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    pll_lock = 1'b0;
    bus_q.delete();
    run_until_end(3, c_end, wd, rh);
    chk("busy2 end_cycle", c_end, 35);
    chk("busy2 done", int'(wd), 1);
    chk("busy2 nbus", bus_q.size(), 6);
    if (bus_q.size() == 6) begin
      chk("busy2 mdiv_write", bus_q[1], {2'b01, 8'h41});
      chk("busy2 odiv_write", bus_q[4], {2'b01, 8'h09});
    end

    // asynchronous reset during the ODIV0 write
    @(negedge clk);
    pll_lock = 1'b0;
    start_req(8'h11, 8'h22, 0);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (mdopc == 2'b01 && mdwdi == 8'h22) found = 1;
    end
    chk("midrst found_odiv_write", int'(found), 1);
    chk("midrst pll_reset_before", pll_reset, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst pll_reset", pll_reset, 0);
    chk("midrst mdopc", mdopc, 0);
    chk("midrst req_ready", req_ready, 1);
    chk("midrst busy", busy, 0);
    repeat (2) @(negedge clk);
    chk("midrst held mdwdi", mdwdi, 0);
    rst_n = 1'b1;
    va = '{8'h33, 8'h44, 8'h00, 5, 1'b1, 2'b00, 37, 6, 28};
    do_vec(va, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
